// File: rtl/riscv_imm_pkg.sv
// Shared definitions for the immediate-generation stage:
// opcode encodings, instruction-format codes and their width.
package riscv_imm_pkg;

    localparam int unsigned FMT_W = 3;

    typedef enum logic [FMT_W-1:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction classifier and sign-extended immediate generator.
module imm_decode
    import riscv_imm_pkg::*;
#(
    parameter int unsigned XLEN         = 64,
    parameter bit          SCALE_BRANCH = 1'b1
) (
    input  logic [31:0]     instr,
    output fmt_e            fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [6:0]  opcode;
    logic [31:0] imm32;

    assign opcode = instr[6:0];

    always_comb begin
        fmt = FMT_ILL;
        if (instr[1:0] == 2'b11) begin
            case (opcode)
                OP_OP:                                       fmt = FMT_R;
                OP_OP32:                                     fmt = (XLEN == 64) ? FMT_R : FMT_ILL;
                OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_FENCE: fmt = FMT_I;
                OP_IMM32:                                    fmt = (XLEN == 64) ? FMT_I : FMT_ILL;
                OP_STORE:                                    fmt = FMT_S;
                OP_BRANCH:                                   fmt = FMT_B;
                OP_LUI, OP_AUIPC:                            fmt = FMT_U;
                OP_JAL:                                      fmt = FMT_J;
                default:                                     fmt = FMT_ILL;
            endcase
        end
    end

    // B/J offsets either keep the implicit zero LSB (byte offset) or stay as a raw halfword count.
    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_B: imm32 = SCALE_BRANCH
                ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
                : {{20{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8]};
            FMT_J: imm32 = SCALE_BRANCH
                ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
                : {{12{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21]};
            default: imm32 = '0;
        endcase
    end

    always_comb begin
        imm       = {XLEN{imm32[31]}};
        imm[31:0] = imm32;
    end

    assign illegal = (fmt == FMT_ILL);

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decode at the input, 2-entry skid buffer
// on the output, and a saturating counter of delivered illegal instructions.
module imm_gen_stage
    import riscv_imm_pkg::*;
#(
    parameter int unsigned XLEN         = 64,
    parameter bit          SCALE_BRANCH = 1'b1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
    } entry_t;

    entry_t dec, main_q, skid_q;
    logic   main_valid, skid_valid;
    logic   accept, out_fire;

    imm_decode #(
        .XLEN        (XLEN),
        .SCALE_BRANCH(SCALE_BRANCH)
    ) u_dec (
        .instr  (in_instr),
        .fmt    (dec.fmt),
        .imm    (dec.imm),
        .illegal(dec.illegal)
    );

    assign dec.instr = in_instr;

    assign in_ready = !skid_valid && !reset;
    assign accept   = in_valid && in_ready;
    assign out_fire = main_valid && out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            main_q        <= '0;
            skid_q        <= '0;
            main_valid    <= 1'b0;
            skid_valid    <= 1'b0;
            illegal_count <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (out_fire && main_q.illegal && illegal_count != '1)
                illegal_count <= illegal_count + CNT_W'(1);
            // The output slot frees up: the older skid entry always wins over a new accept.
            if (!main_valid || out_ready) begin
                if (skid_valid) begin
                    main_q     <= skid_q;
                    main_valid <= 1'b1;
                    skid_valid <= 1'b0;
                end else begin
                    main_valid <= accept;
                    if (accept)
                        main_q <= dec;
                end
            end else if (accept) begin
                skid_q     <= dec;
                skid_valid <= 1'b1;
            end
        end
    end

    assign out_valid   = main_valid;
    assign out_instr   = main_q.instr;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench: two stage instances (RV64 scaled, RV32 unscaled with a 2-bit counter)
// share stimulus; a vector table plus stall and flush sequences.
module tb_imm_gen_stage;

    logic clock = 1'b0;
    logic reset, flush, in_valid, out_ready;
    logic [31:0] in_instr;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_instr;
    logic [63:0] a_out_imm;
    logic [2:0]  a_out_fmt;
    logic [15:0] a_cnt;

    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [31:0] b_out_instr;
    logic [31:0] b_out_imm;
    logic [2:0]  b_out_fmt;
    logic [1:0]  b_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    imm_gen_stage #(.XLEN(64), .SCALE_BRANCH(1'b1), .CNT_W(16)) dut_a (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_instr(a_out_instr),
        .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_illegal(a_out_illegal),
        .illegal_count(a_cnt)
    );

    imm_gen_stage #(.XLEN(32), .SCALE_BRANCH(1'b0), .CNT_W(2)) dut_b (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_instr(b_out_instr),
        .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_illegal),
        .illegal_count(b_cnt)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm_a;
        logic [2:0]  fmt_a;
        logic        ill_a;
        logic [31:0] imm_b;
        logic [2:0]  fmt_b;
        logic        ill_b;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sinstr(input int k);
        logic [11:0] im;
        im = 12'(100 + k);
        return {im, 5'd0, 3'd0, 5'd1, 7'b0010011};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_a, exp_b, wr, rd;

        vecs[0]  = '{32'hFF813083, 64'hFFFFFFFFFFFFFFF8, 3'd1, 1'b0, 32'hFFFFFFF8, 3'd1, 1'b0};
        vecs[1]  = '{32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0, 32'hFFFFFFFE, 3'd3, 1'b0};
        vecs[2]  = '{32'h123452B7, 64'h0000000012345000, 3'd4, 1'b0, 32'h12345000, 3'd4, 1'b0};
        vecs[3]  = '{32'h800002B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0, 32'h80000000, 3'd4, 1'b0};
        vecs[4]  = '{32'h003100B3, 64'h0,                3'd0, 1'b0, 32'h0,        3'd0, 1'b0};
        vecs[5]  = '{32'h003100BB, 64'h0,                3'd0, 1'b0, 32'h0,        3'd7, 1'b1};
        vecs[6]  = '{32'hFE112E23, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0, 32'hFFFFFFFC, 3'd2, 1'b0};
        vecs[7]  = '{32'h008000EF, 64'h0000000000000008, 3'd5, 1'b0, 32'h00000004, 3'd5, 1'b0};
        vecs[8]  = '{32'hFFDFF06F, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0, 32'hFFFFFFFE, 3'd5, 1'b0};
        vecs[9]  = '{32'h7FF00093, 64'h00000000000007FF, 3'd1, 1'b0, 32'h000007FF, 3'd1, 1'b0};
        vecs[10] = '{32'h00000000, 64'h0,                3'd7, 1'b1, 32'h0,        3'd7, 1'b1};
        vecs[11] = '{32'h0000007F, 64'h0,                3'd7, 1'b1, 32'h0,        3'd7, 1'b1};
        vecs[12] = '{32'h00000012, 64'h0,                3'd7, 1'b1, 32'h0,        3'd7, 1'b1};
        vecs[13] = '{32'h0010809B, 64'h0000000000000001, 3'd1, 1'b0, 32'h0,        3'd7, 1'b1};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
        exp_a = 0; exp_b = 0;

        // reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready",  64'(a_in_ready), 64'd0);
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_imm",       a_out_imm, 64'd0);
        check("rst_fmt",       64'(a_out_fmt), 64'd0);
        check("rst_instr",     64'(a_out_instr), 64'd0);
        check("rst_illegal",   64'(a_out_illegal), 64'd0);
        check("rst_cnt",       64'(a_cnt), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(a_in_ready), 64'd1);

        // table vectors, one instruction every two cycles with the consumer ready
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            in_valid = 1'b1; in_instr = vecs[i].instr; out_ready = 1'b1;
            @(posedge clock);
            #1;
            in_valid = 1'b0;
            check($sformatf("v%0d_valid_a", i), 64'(a_out_valid), 64'd1);
            check($sformatf("v%0d_instr_a", i), 64'(a_out_instr), 64'(vecs[i].instr));
            check($sformatf("v%0d_imm_a", i),   a_out_imm, vecs[i].imm_a);
            check($sformatf("v%0d_fmt_a", i),   64'(a_out_fmt), 64'(vecs[i].fmt_a));
            check($sformatf("v%0d_ill_a", i),   64'(a_out_illegal), 64'(vecs[i].ill_a));
            check($sformatf("v%0d_valid_b", i), 64'(b_out_valid), 64'd1);
            check($sformatf("v%0d_imm_b", i),   64'(b_out_imm), 64'(vecs[i].imm_b));
            check($sformatf("v%0d_fmt_b", i),   64'(b_out_fmt), 64'(vecs[i].fmt_b));
            check($sformatf("v%0d_ill_b", i),   64'(b_out_illegal), 64'(vecs[i].ill_b));
            if (vecs[i].ill_a) exp_a++;
            if (vecs[i].ill_b && exp_b < 3) exp_b++;
            @(posedge clock);
            #1;
            check($sformatf("v%0d_cnt_a", i),   64'(a_cnt), 64'(exp_a));
            check($sformatf("v%0d_cnt_b", i),   64'(b_cnt), 64'(exp_b));
            check($sformatf("v%0d_drain", i),   64'(a_out_valid), 64'd0);
        end

        // stream of 8 with a 3-cycle consumer stall
        wr = 0; rd = 0;
        for (int c = 0; c < 40 && rd < 8; c++) begin
            @(negedge clock);
            in_valid  = (wr < 8);
            in_instr  = sinstr(wr);
            out_ready = !(c >= 1 && c <= 3);
            #1;
            if (c == 2 || c == 3) begin
                check($sformatf("stall_in_ready_c%0d", c), 64'(a_in_ready), 64'd0);
                check($sformatf("stall_hold_c%0d", c), 64'(a_out_instr), 64'(sinstr(0)));
            end
            if (a_out_valid && out_ready) begin
                check($sformatf("stream_instr_%0d", rd), 64'(a_out_instr), 64'(sinstr(rd)));
                check($sformatf("stream_imm_%0d", rd), a_out_imm, 64'(100 + rd));
                rd++;
            end
            if (in_valid && a_in_ready) wr++;
        end
        check("stream_count", 64'(rd), 64'd8);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check("stream_empty", 64'(a_out_valid), 64'd0);

        // flush with both entries full
        @(negedge clock);
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0000007F;
        @(negedge clock);
        in_instr = 32'h00000000;
        @(negedge clock);
        check("full_in_ready", 64'(a_in_ready), 64'd0);
        flush = 1'b1; in_instr = 32'h00500093;
        @(posedge clock);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush2_valid", 64'(a_out_valid), 64'd0);
        check("flush2_in_ready", 64'(a_in_ready), 64'd1);
        check("flush2_cnt", 64'(a_cnt), 64'(exp_a));

        // flush with one entry and an input accepted in the flush cycle
        @(negedge clock);
        in_valid = 1'b1; in_instr = 32'h0000007F;
        @(negedge clock);
        check("flush1_in_ready", 64'(a_in_ready), 64'd1);
        flush = 1'b1; in_instr = 32'h00500093;
        @(posedge clock);
        #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("flush1_valid", 64'(a_out_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            check($sformatf("flush_no_emit_%0d", k), 64'(a_out_valid), 64'd0);
        end
        check("flush1_cnt_a", 64'(a_cnt), 64'(exp_a));
        check("flush1_cnt_b", 64'(b_cnt), 64'(exp_b));

        // recovery after flush
        @(negedge clock);
        in_valid = 1'b1; in_instr = 32'h00700093;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check("recover_valid", 64'(a_out_valid), 64'd1);
        check("recover_imm", a_out_imm, 64'd7);

        @(posedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
